// File: rtl/icc_branch_unit_pkg.sv
// Shared definitions for the integer condition codes and Bicc evaluation:
// cond encodings, ICC bit positions, branch-unit state and the cc-op predicate.
package icc_branch_unit_pkg;

  localparam logic [3:0] COND_N   = 4'b0000;
  localparam logic [3:0] COND_E   = 4'b0001;
  localparam logic [3:0] COND_LE  = 4'b0010;
  localparam logic [3:0] COND_L   = 4'b0011;
  localparam logic [3:0] COND_LEU = 4'b0100;
  localparam logic [3:0] COND_CS  = 4'b0101;
  localparam logic [3:0] COND_NEG = 4'b0110;
  localparam logic [3:0] COND_VS  = 4'b0111;
  localparam logic [3:0] COND_A   = 4'b1000;
  localparam logic [3:0] COND_NE  = 4'b1001;
  localparam logic [3:0] COND_G   = 4'b1010;
  localparam logic [3:0] COND_GE  = 4'b1011;
  localparam logic [3:0] COND_GU  = 4'b1100;
  localparam logic [3:0] COND_CC  = 4'b1101;
  localparam logic [3:0] COND_POS = 4'b1110;
  localparam logic [3:0] COND_VC  = 4'b1111;

  localparam int ICC_N = 3;
  localparam int ICC_Z = 2;
  localparam int ICC_V = 1;
  localparam int ICC_C = 0;

  typedef enum logic {
    IDLE = 1'b0,
    DS   = 1'b1
  } br_state_t;

  // cc-modifying ALU ops occupy op[5]==0, op[4]==1 in the opcode map.
  function automatic logic is_cc_op(input logic [5:0] op);
    return !op[5] && op[4];
  endfunction

endpackage

// File: rtl/icc_cond_eval.sv
// Combinational Bicc condition evaluator: cond field + {N,Z,V,C} -> taken.
// Kept standalone so a branch predictor can reuse the same decode.
module icc_cond_eval
  import icc_branch_unit_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       taken
);

  logic n, z, v, c;
  logic base;

  assign n = flags[ICC_N];
  assign z = flags[ICC_Z];
  assign v = flags[ICC_V];
  assign c = flags[ICC_C];

  // Upper eight conds are the complements of the lower eight; BN inverts to BA.
  always_comb begin
    base = 1'b0;
    unique case (cond[2:0])
      3'd0: base = 1'b0;
      3'd1: base = z;
      3'd2: base = z | (n ^ v);
      3'd3: base = n ^ v;
      3'd4: base = c | z;
      3'd5: base = c;
      3'd6: base = n;
      3'd7: base = v;
    endcase
  end

  assign taken = cond[3] ? ~base : base;

endmodule

// File: rtl/icc_branch_unit.sv
// Integer condition-code register plus Bicc resolution with same-cycle bypass
// and delay-slot tracking (annulment, branch-in-delay-slot error).
module icc_branch_unit
  import icc_branch_unit_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       stall,
  input  logic       cc_we,
  input  logic       alu_n,
  input  logic       alu_z,
  input  logic       alu_v,
  input  logic       alu_c,
  input  logic       br_valid,
  input  logic [3:0] br_cond,
  input  logic       br_annul,
  output logic [3:0] icc,
  output logic       br_taken,
  output logic       annul_next,
  output logic       err_dcti
);

  br_state_t  state;
  logic [3:0] alu_flags;
  logic [3:0] eff_flags;
  logic       squashed;
  logic       cc_write;
  logic       cond_taken;
  logic       annul;

  assign alu_flags = {alu_n, alu_z, alu_v, alu_c};

  // A squashed delay-slot instruction must neither write cc nor feed the bypass.
  assign squashed  = (state == DS) && annul_next;
  assign cc_write  = cc_we && !squashed;
  assign eff_flags = cc_write ? alu_flags : icc;

  icc_cond_eval u_cond_eval (
    .cond  (br_cond),
    .flags (eff_flags),
    .taken (cond_taken)
  );

  assign annul = br_annul && (!cond_taken || (br_cond == COND_A));

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      icc        <= 4'b0000;
      br_taken   <= 1'b0;
      annul_next <= 1'b0;
      err_dcti   <= 1'b0;
    end else if (!stall) begin
      if (cc_write) icc <= alu_flags;
      br_taken   <= 1'b0;
      annul_next <= 1'b0;
      err_dcti   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (br_valid) begin
            br_taken   <= cond_taken;
            annul_next <= annul;
            state      <= DS;
          end
        end
        DS: begin
          err_dcti <= br_valid;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icc_branch_unit.sv
// Bench for icc_branch_unit: directed test-plan steps followed by random
// traffic, all checked against a cycle-level reference model of the rules.
module tb_icc_branch_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       stall;
  logic       cc_we;
  logic       alu_n, alu_z, alu_v, alu_c;
  logic       br_valid;
  logic [3:0] br_cond;
  logic       br_annul;
  logic [3:0] icc;
  logic       br_taken;
  logic       annul_next;
  logic       err_dcti;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [3:0] icc;
    bit         in_ds;
    bit         taken;
    bit         annul;
    bit         err;
  } model_t;

  model_t m;

  icc_branch_unit dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .cc_we      (cc_we),
    .alu_n      (alu_n),
    .alu_z      (alu_z),
    .alu_v      (alu_v),
    .alu_c      (alu_c),
    .br_valid   (br_valid),
    .br_cond    (br_cond),
    .br_annul   (br_annul),
    .icc        (icc),
    .br_taken   (br_taken),
    .annul_next (annul_next),
    .err_dcti   (err_dcti)
  );

  always #5 clk = ~clk;

  // Bicc truth table written out per mnemonic.
  function automatic bit cond_true(input logic [3:0] cond, input logic [3:0] f);
    bit n, z, v, c;
    {n, z, v, c} = f;
    case (cond)
      4'h0: return 0;
      4'h1: return z;
      4'h2: return z || (n != v);
      4'h3: return n != v;
      4'h4: return c || z;
      4'h5: return c;
      4'h6: return n;
      4'h7: return v;
      4'h8: return 1;
      4'h9: return !z;
      4'hA: return !(z || (n != v));
      4'hB: return n == v;
      4'hC: return !(c || z);
      4'hD: return !c;
      4'hE: return !n;
      default: return !v;
    endcase
  endfunction

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".icc"}, icc, m.icc);
    check({tag, ".br_taken"}, {3'b0, br_taken}, {3'b0, m.taken});
    check({tag, ".annul_next"}, {3'b0, annul_next}, {3'b0, m.annul});
    check({tag, ".err_dcti"}, {3'b0, err_dcti}, {3'b0, m.err});
  endtask

  // Effect of one clock edge on the architectural model.
  task automatic model_edge();
    bit         squash;
    logic [3:0] eff;
    logic [3:0] f;
    if (stall) return;
    f      = {alu_n, alu_z, alu_v, alu_c};
    squash = m.in_ds && m.annul;
    eff    = (cc_we && !squash) ? f : m.icc;
    if (m.in_ds) begin
      m.err   = br_valid;
      m.taken = 0;
      m.annul = 0;
      m.in_ds = 0;
    end else if (br_valid) begin
      m.taken = cond_true(br_cond, eff);
      m.annul = br_annul && (!m.taken || br_cond == 4'h8);
      m.err   = 0;
      m.in_ds = 1;
    end else begin
      m.taken = 0;
      m.annul = 0;
      m.err   = 0;
    end
    if (cc_we && !squash) m.icc = f;
  endtask

  task automatic drive(input bit s, input bit we, input logic [3:0] f,
                       input bit bv, input logic [3:0] cond, input bit a);
    stall    = s;
    cc_we    = we;
    {alu_n, alu_z, alu_v, alu_c} = f;
    br_valid = bv;
    br_cond  = cond;
    br_annul = a;
  endtask

  task automatic cycle(input string tag, input bit s, input bit we, input logic [3:0] f,
                       input bit bv, input logic [3:0] cond, input bit a);
    drive(s, we, f, bv, cond, a);
    @(posedge clk);
    #1;
    model_edge();
    check_all(tag);
  endtask

  task automatic model_reset();
    m = '{icc: 4'b0000, in_ds: 0, taken: 0, annul: 0, err: 0};
  endtask

  initial begin
    drive(0, 0, 4'h0, 0, 4'h0, 0);
    reset = 1'b1;
    model_reset();
    #12;
    check_all("reset");
    reset = 1'b0;
    @(posedge clk);
    #1;
    model_edge();

    // subcc 7-1 then BG a=0
    cycle("subcc_7_1", 0, 1, 4'b0000, 0, 4'h0, 0);
    cycle("bg_after_cc", 0, 0, 4'h0, 1, 4'b1010, 0);
    check("bg.taken_const", {3'b0, br_taken}, 4'd1);
    check("bg.icc_const", icc, 4'b0000);
    cycle("bg_slot", 0, 0, 4'h0, 0, 4'h0, 0);

    // subcc 5-5 bypassed into BNE a=1, then annulled slot tries to write 1111
    cycle("bne_bypass", 0, 1, 4'b0100, 1, 4'b1001, 1);
    check("bne.taken_const", {3'b0, br_taken}, 4'd0);
    check("bne.annul_const", {3'b0, annul_next}, 4'd1);
    check("bne.icc_const", icc, 4'b0100);
    cycle("squashed_slot", 0, 1, 4'b1111, 0, 4'h0, 0);
    check("squash.icc_const", icc, 4'b0100);

    cycle("ba_a1", 0, 0, 4'h0, 1, 4'b1000, 1);
    cycle("ba_slot", 0, 0, 4'h0, 0, 4'h0, 0);
    cycle("bn_a1", 0, 0, 4'h0, 1, 4'b0000, 1);
    cycle("bn_a1_slot", 0, 0, 4'h0, 0, 4'h0, 0);
    cycle("bn_a0", 0, 0, 4'h0, 1, 4'b0000, 0);
    cycle("bn_a0_slot", 0, 0, 4'h0, 0, 4'h0, 0);

    // Back-to-back branches
    cycle("b2b_first", 0, 0, 4'h0, 1, 4'b1000, 0);
    cycle("b2b_second", 0, 0, 4'h0, 1, 4'b1000, 0);
    check("b2b.err_const", {3'b0, err_dcti}, 4'd1);
    cycle("b2b_after", 0, 0, 4'h0, 0, 4'h0, 0);

    // Stall held for three cycles in DS
    cycle("stall_br", 0, 0, 4'h0, 1, 4'b1000, 1);
    for (int i = 0; i < 3; i++) cycle("stall_hold", 1, 1, 4'b1111, 1, 4'b0000, 0);
    check("stall.taken_const", {3'b0, br_taken}, 4'd1);
    cycle("stall_release", 0, 0, 4'h0, 0, 4'h0, 0);
    cycle("post_stall_br", 0, 0, 4'h0, 1, 4'b1000, 0);
    cycle("post_stall_slot", 0, 0, 4'h0, 0, 4'h0, 0);

    // Asynchronous reset in DS with icc=1010
    cycle("load_1010", 0, 1, 4'b1010, 0, 4'h0, 0);
    cycle("br_before_rst", 0, 0, 4'h0, 1, 4'b1000, 0);
    reset = 1'b1;
    #1;
    model_reset();
    check_all("async_reset");
    #2;
    reset = 1'b0;
    cycle("be_after_rst", 0, 0, 4'h0, 1, 4'b0001, 0);
    check("be.taken_const", {3'b0, br_taken}, 4'd0);
    cycle("be_slot", 0, 0, 4'h0, 0, 4'h0, 0);

    for (int i = 0; i < 400; i++) begin
      cycle("random",
            ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 1) == 1),
            4'($urandom_range(0, 15)),
            ($urandom_range(0, 1) == 1),
            4'($urandom_range(0, 15)),
            ($urandom_range(0, 1) == 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
